// File: rtl/filter_ctrl_pkg.sv
// Shared types and default widths for the filter channel controller.
package filter_ctrl_pkg;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam int DEF_DIV_W = 8;
  localparam int DEF_CNT_W = 16;
endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous bit, cleared to 0 on reset.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/filter_ctrl.sv
// Filter channel controller: cclk/div2/lo generation, comparator sampling on
// phi1b_dig rising edges, feedback bit and windowed high-count with handshake.
module filter_ctrl
  import filter_ctrl_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             en,
  input  logic [DIV_W-1:0] clkdiv,
  input  logic [3:0]       lo_div,
  input  logic [CNT_W-1:0] win_len,
  input  logic             high_buf,
  input  logic             phi1b_dig,
  output logic             cclk,
  output logic             div2,
  output logic             lo,
  output logic             fb1,
  output logic [CNT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ovf,
  input  logic             ovf_clr,
  output logic             busy
);
  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       lo_cnt;
  logic [CNT_W-1:0] acc;
  logic [CNT_W-1:0] win_cnt;
  logic             phi_d;
  logic             high_s;
  logic             phi_s;
  logic [1:0]       async_in;
  logic [1:0]       sync_out;
  logic             samp;
  logic             eow;
  logic [CNT_W-1:0] acc_sum;

  assign async_in = {phi1b_dig, high_buf};

  for (genvar gi = 0; gi < 2; gi++) begin : g_sync
    sync2 u_sync (
      .clk (wb_clk_i),
      .rst (wb_rst_i),
      .d   (async_in[gi]),
      .q   (sync_out[gi])
    );
  end

  assign high_s = sync_out[0];
  assign phi_s  = sync_out[1];

  assign samp    = (state == RUN) && phi_s && !phi_d;
  // A sample coinciding with the disable edge is dropped, so no result can load then.
  assign eow     = samp && en && (win_cnt == win_len);
  assign acc_sum = (high_s && (&acc)) ? acc : acc + {{(CNT_W-1){1'b0}}, high_s};

  // Run-state FSM and clock generation.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state   <= IDLE;
      busy    <= 1'b0;
      div_cnt <= '0;
      lo_cnt  <= '0;
      cclk    <= 1'b0;
      div2    <= 1'b0;
      lo      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          div_cnt <= '0;
          lo_cnt  <= '0;
          cclk    <= 1'b0;
          div2    <= 1'b0;
          lo      <= 1'b0;
          if (en) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (!en) begin
            state   <= IDLE;
            busy    <= 1'b0;
            div_cnt <= '0;
            lo_cnt  <= '0;
            cclk    <= 1'b0;
            div2    <= 1'b0;
            lo      <= 1'b0;
          end else if (div_cnt >= clkdiv) begin
            div_cnt <= '0;
            cclk    <= ~cclk;
            if (!cclk) begin
              div2 <= ~div2;
              if (lo_cnt == lo_div) begin
                lo     <= ~lo;
                lo_cnt <= '0;
              end else begin
                lo_cnt <= lo_cnt + 4'd1;
              end
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sampling, feedback and window accumulation.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      phi_d   <= 1'b0;
      fb1     <= 1'b0;
      acc     <= '0;
      win_cnt <= '0;
    end else begin
      phi_d <= phi_s;
      if (state != RUN || !en) begin
        fb1     <= 1'b0;
        acc     <= '0;
        win_cnt <= '0;
      end else if (samp) begin
        fb1 <= high_s;
        if (win_cnt == win_len) begin
          acc     <= '0;
          win_cnt <= '0;
        end else begin
          acc     <= acc_sum;
          win_cnt <= win_cnt + CNT_W'(1);
        end
      end
    end
  end

  // Result handshake stays live in IDLE so a pending count can still drain.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (eow) begin
        out_data  <= acc_sum;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (eow && out_valid && !out_ready) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_filter_ctrl.sv
// Self-checking bench for filter_ctrl: divider periods, windowed counts,
// overflow, disable/re-enable, asynchronous reset and count saturation.
module tb_filter_ctrl;
  logic        clk;
  logic        rst;
  logic        en;
  logic [7:0]  clkdiv;
  logic [3:0]  lo_div;
  logic [15:0] win_len;
  logic [3:0]  win_len_sat;
  logic        high_buf;
  logic        phi;
  logic        out_ready;
  logic        ovf_clr;

  logic        cclk, div2, lo, fb1, out_valid, ovf, busy;
  logic [15:0] out_data;
  logic        s_cclk, s_div2, s_lo, s_fb1, s_out_valid, s_ovf, s_busy;
  logic [3:0]  s_out_data;

  int checks = 0;
  int errors = 0;

  logic        fb_q[$];
  logic [15:0] res_q[$];
  logic [3:0]  sat_q[$];

  filter_ctrl #(.DIV_W(8), .CNT_W(16)) dut (
    .wb_clk_i (clk), .wb_rst_i (rst), .en (en), .clkdiv (clkdiv),
    .lo_div (lo_div), .win_len (win_len), .high_buf (high_buf),
    .phi1b_dig (phi), .cclk (cclk), .div2 (div2), .lo (lo), .fb1 (fb1),
    .out_data (out_data), .out_valid (out_valid), .out_ready (out_ready),
    .ovf (ovf), .ovf_clr (ovf_clr), .busy (busy)
  );

  filter_ctrl #(.DIV_W(8), .CNT_W(4)) dut_sat (
    .wb_clk_i (clk), .wb_rst_i (rst), .en (en), .clkdiv (clkdiv),
    .lo_div (lo_div), .win_len (win_len_sat), .high_buf (high_buf),
    .phi1b_dig (phi), .cclk (s_cclk), .div2 (s_div2), .lo (s_lo), .fb1 (s_fb1),
    .out_data (s_out_data), .out_valid (s_out_valid), .out_ready (out_ready),
    .ovf (s_ovf), .ovf_clr (ovf_clr), .busy (s_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One phi1b_dig pulse (3 cycles high, 3 low); fb1 is due on the 3rd edge.
  task automatic pulse(input logic h, input logic rdy_at_sample);
    high_buf = h;
    phi      = 1'b1;
    fb_q.push_back(h);
    tick(2);
    if (rdy_at_sample) out_ready = 1'b1;
    tick(1);
    if (rdy_at_sample) out_ready = 1'b0;
    checks++;
    begin
      logic exp_fb;
      exp_fb = fb_q.pop_front();
      if (fb1 !== exp_fb) begin
        errors++;
        $display("FAIL fb1: got %b expected %b", fb1, exp_fb);
      end
    end
    phi = 1'b0;
    tick(3);
  endtask

  task automatic run_window(input logic [15:0] pat, input int n, input logic rdy_last);
    logic [15:0] cnt;
    logic [15:0] exp;
    cnt = '0;
    for (int i = 0; i < n; i++) begin
      pulse(pat[i], rdy_last && (i == n - 1));
      if (pat[i] && cnt != 16'hFFFF) cnt = cnt + 16'd1;
    end
    res_q.push_back(cnt);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL window_valid: got %b expected 1", out_valid);
    end
    exp = res_q.pop_front();
    checks++;
    if (out_data !== exp) begin
      errors++;
      $display("FAIL window_data: got %0d expected %0d", out_data, exp);
    end
    $display("window done: out_data=%0d out_valid=%b ovf=%b", out_data, out_valid, ovf);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    checks++;
    if ({cclk, div2, lo, fb1, out_valid, ovf, busy} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000000", {cclk, div2, lo, fb1, out_valid, ovf, busy});
    end
    checks++;
    if (out_data !== 16'd0) begin
      errors++;
      $display("FAIL reset_data: got %0d expected 0", out_data);
    end
    rst = 1'b0;
    tick(1);
    $display("reset checked");
  endtask

  task automatic measure(output int pc, output int pd, output int pl);
    int lc, ld, ll;
    logic pcv, pdv, plv;
    pc = 0; pd = 0; pl = 0; lc = -1; ld = -1; ll = -1;
    pcv = cclk; pdv = div2; plv = lo;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (cclk && !pcv) begin if (lc >= 0) pc = i - lc; lc = i; end
      if (div2 && !pdv) begin if (ld >= 0) pd = i - ld; ld = i; end
      if (lo && !plv)   begin if (ll >= 0) pl = i - ll; ll = i; end
      pcv = cclk; pdv = div2; plv = lo;
    end
  endtask

  task automatic test_divider();
    int pc, pd, pl;
    clkdiv = 8'd1;
    lo_div = 4'd0;
    en     = 1'b1;
    tick(1);
    checks++;
    if (busy !== 1'b1 || cclk !== 1'b0) begin
      errors++;
      $display("FAIL en_rise: busy=%b cclk=%b expected busy=1 cclk=0", busy, cclk);
    end
    tick(1);
    checks++;
    if (cclk !== 1'b0) begin
      errors++;
      $display("FAIL cclk_early: got %b expected 0", cclk);
    end
    tick(1);
    checks++;
    if (cclk !== 1'b1) begin
      errors++;
      $display("FAIL cclk_first_toggle: got %b expected 1", cclk);
    end
    measure(pc, pd, pl);
    $display("clkdiv=1 lo_div=0: cclk=%0d div2=%0d lo=%0d", pc, pd, pl);
    checks++;
    if (pc != 4) begin errors++; $display("FAIL cclk_period_div1: got %0d expected 4", pc); end
    checks++;
    if (pd != 8) begin errors++; $display("FAIL div2_period_div1: got %0d expected 8", pd); end
    checks++;
    if (pl != 8) begin errors++; $display("FAIL lo_period_div1: got %0d expected 8", pl); end
    clkdiv = 8'd0;
    measure(pc, pd, pl);
    $display("clkdiv=0 lo_div=0: cclk=%0d div2=%0d lo=%0d", pc, pd, pl);
    checks++;
    if (pc != 2) begin errors++; $display("FAIL cclk_period_div0: got %0d expected 2", pc); end
    checks++;
    if (pd != 4) begin errors++; $display("FAIL div2_period_div0: got %0d expected 4", pd); end
    lo_div = 4'd2;
    measure(pc, pd, pl);
    $display("clkdiv=0 lo_div=2: lo=%0d", pl);
    checks++;
    if (pl != 12) begin errors++; $display("FAIL lo_period_lodiv2: got %0d expected 12", pl); end
  endtask

  task automatic test_window();
    win_len = 16'd7;
    run_window(16'h006D, 8, 1'b0);
    tick(5);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'd5) begin
      errors++;
      $display("FAIL window_hold: valid=%b data=%0d expected valid=1 data=5", out_valid, out_data);
    end
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL window_consume: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_overflow();
    run_window(16'h006D, 8, 1'b0);
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_first: got %b expected 0", ovf); end
    run_window(16'h0007, 8, 1'b0);
    checks++;
    if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", ovf); end
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %b expected 0", ovf); end
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    run_window(16'h006D, 8, 1'b0);
    run_window(16'h0007, 8, 1'b1);
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_ready_at_end: got %b expected 0", ovf); end
  endtask

  task automatic test_disable();
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b0);
    pulse(1'b1, 1'b0);
    en = 1'b0;
    tick(1);
    checks++;
    if ({cclk, div2, lo, fb1, busy} !== 5'b0) begin
      errors++;
      $display("FAIL disable_outputs: got %b expected 00000", {cclk, div2, lo, fb1, busy});
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'd3) begin
      errors++;
      $display("FAIL disable_retain: valid=%b data=%0d expected valid=1 data=3", out_valid, out_data);
    end
    $display("disabled: busy=%b out_valid=%b", busy, out_valid);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    en = 1'b1;
    tick(1);
    run_window(16'h00C2, 8, 1'b0);
  endtask

  task automatic test_async_reset();
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({cclk, div2, lo, fb1, out_valid, ovf, busy} !== 7'b0 || out_data !== 16'd0) begin
      errors++;
      $display("FAIL async_reset: flags=%b data=%0d expected 0", {cclk, div2, lo, fb1, out_valid, ovf, busy}, out_data);
    end
    checks++;
    if ({s_out_valid, s_busy, s_fb1} !== 3'b0) begin
      errors++;
      $display("FAIL async_reset_sat: got %b expected 000", {s_out_valid, s_busy, s_fb1});
    end
    tick(1);
    rst = 1'b0;
    tick(2);
    $display("async reset checked, busy=%b", busy);
  endtask

  task automatic test_saturation();
    logic [3:0] cnt;
    logic [3:0] exp;
    cnt = '0;
    for (int i = 0; i < 16; i++) begin
      pulse(1'b1, 1'b0);
      if (cnt != 4'hF) cnt = cnt + 4'd1;
    end
    sat_q.push_back(cnt);
    exp = sat_q.pop_front();
    checks++;
    if (s_out_valid !== 1'b1 || s_out_data !== exp) begin
      errors++;
      $display("FAIL saturation: valid=%b data=%0d expected valid=1 data=%0d", s_out_valid, s_out_data, exp);
    end
    checks++;
    if (out_data !== 16'd8 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL sat_main: data=%0d ovf=%b expected data=8 ovf=1", out_data, ovf);
    end
    $display("saturation window: out_data=%0d", s_out_data);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clkdiv = 8'd1; lo_div = 4'd0; win_len = 16'd7;
    win_len_sat = 4'd15; high_buf = 1'b0; phi = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
    test_reset();
    test_divider();
    test_window();
    test_overflow();
    test_disable();
    test_async_reset();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/filter_ctrl.md
# filter_ctrl

Digital-core controller for one filter channel: the digital end of the filter macro's clock/LO/feedback interface. Generates `cclk`, `div2` and `lo` from the system clock. Captures the comparator output `high_buf` on each `phi1b_dig` rising edge and drives it back as the 1-bit feedback `fb1`. Accumulates comparator highs over a programmable window and delivers each window count over a valid/ready handshake.

## Interface
Parameters:
- `DIV_W`, default 8: width of the `cclk` half-period divider.
- `CNT_W`, default 16: width of the window length and the count.

Ports (one clock; reset is asynchronous and active-high):
- `wb_clk_i` in 1: system clock; all state on its rising edge.
- `wb_rst_i` in 1: asynchronous, active-high reset.
- `en` in 1: run enable.
- `clkdiv` in DIV_W: `cclk` half-period is `clkdiv+1` wb_clk cycles.
- `lo_div` in 4: `lo` toggles every `lo_div+1` `cclk` rising edges.
- `win_len` in CNT_W: a window is `win_len+1` samples.
- `high_buf` in 1: comparator output; asynchronous to `wb_clk_i`.
- `phi1b_dig` in 1: sample clock from the macro; asynchronous, treated as data.
- `cclk` out 1: filter clock.
- `div2` out 1: `cclk`/2.
- `lo` out 1: LO square wave.
- `fb1` out 1: feedback bit, equal to the last sampled comparator value.
- `out_data` out CNT_W: window count.
- `out_valid` out 1: `out_data` is valid.
- `out_ready` in 1: consumer accepts `out_data`.
- `ovf` out 1: sticky flag; an unconsumed result was overwritten.
- `ovf_clr` in 1: clears `ovf`.
- `busy` out 1: controller is in RUN.

## Operation
- Reset value of all outputs is 0. The FSM resets to IDLE.
- FSM states:
  - IDLE → RUN when `en`=1.
  - RUN → IDLE when `en`=0, synchronously, next edge.
  - `busy` = (state==RUN), registered.
- In IDLE:
  - `cclk`, `div2`, `lo` and `fb1` are held at 0.
  - The divider, LO counter, window counter and accumulator are cleared.
  - `out_data`, `out_valid` and `ovf` are retained, and the handshake stays live.
- `cclk` divider (RUN):
  - `div_cnt` increments each cycle.
  - When `div_cnt >= clkdiv`: `div_cnt` returns to 0 and `cclk` toggles.
  - The `>=` makes a mid-run decrease of `clkdiv` take effect immediately.
- `div2` toggles on each `cclk` 0→1 transition.
- `lo`: `lo_cnt` counts `cclk` 0→1 transitions. At `lo_cnt == lo_div`, `lo` toggles and `lo_cnt` wraps to 0.
- Sampling:
  - `high_buf` and `phi1b_dig` each pass through a 2-FF synchronizer, giving `high_s` and `phi_s`.
  - `phi_d` is `phi_s` delayed by one register.
  - `samp` = RUN & `phi_s` & ~`phi_d`.
- On `samp`:
  - `fb1` <= `high_s`.
  - `acc` increments if `high_s`; `acc` saturates at all-ones.
  - `win_cnt` increments.
- End of window: `samp` and `win_cnt == win_len`.
  - `out_data` <= `acc` + `high_s`, saturating.
  - `out_valid` <= 1.
  - `acc` and `win_cnt` <= 0.
- Handshake:
  - `out_data` is stable while `out_valid`=1 and no new window ends.
  - `out_valid` & `out_ready` clears `out_valid` unless a window ends in the same cycle.
  - End of window while `out_valid`=1 & `out_ready`=0: `out_data` is overwritten, `out_valid` stays 1, `ovf` <= 1.
  - End of window while `out_valid`=1 & `out_ready`=1: new data loads, `out_valid` stays 1, no overflow.
- `ovf_clr` clears `ovf`. A simultaneous set wins.
- Asynchronous `wb_rst_i` mid-run: all state clears immediately, without waiting for a clock edge.
- `win_len` and `lo_div` are compared live. A change lowering the limit below the current count takes effect at the next wrap of the free-running counter, with no X or lockup.

## Timing
- `en` rise at edge k: state=RUN and `busy`=1 after edge k. First `cclk` toggle after edge k+1+`clkdiv`.
- `cclk` period = 2(`clkdiv`+1) wb_clk cycles. `div2` period = 2× that.
- `lo` period = 2(`lo_div`+1) `cclk` periods.
- Latency, `phi1b_dig` rise → `fb1` / `out_data` / `out_valid` update: the 3rd `wb_clk_i` rising edge after the rise (setup met).
- `phi1b_dig` high and low phases must each be ≥2 wb_clk cycles. Shorter pulses may be missed.
- `en` fall: IDLE and outputs low after the next edge.

## Structure
- Package `filter_ctrl_pkg` contains:
  - the state enum {IDLE, RUN};
  - default `DIV_W` / `CNT_W` constants.
- Sub-module `sync2`: a 2-FF synchronizer with asynchronous active-high reset to 0. It is instantiated twice, for `high_buf` and `phi1b_dig`.

## Test plan
- Divider: `clkdiv`=1, `lo_div`=0, `en`=1 → `cclk` period 4 cycles, `div2` period 8, `lo` period 8. With `clkdiv`=0 → `cclk` period 2.
- Window count: `win_len`=7, eight `phi1b_dig` pulses with `high_buf` = 1,0,1,1,0,1,1,0 → `fb1` tracks each value 3 cycles after each pulse; `out_data`=5, `out_valid`=1, held until `out_ready`.
- Overflow: `out_ready`=0 across two windows, results 5 then 3 → `out_data`=3, `ovf`=1. Pulse `ovf_clr` → `ovf`=0. With `out_ready`=1 at the second window end → `ovf` stays 0.
- Disable mid-window: `en`=0 after 3 samples → `cclk`/`div2`/`lo`/`fb1`=0 next edge, pending `out_valid` retained. Re-enable → a fresh 8-sample window.
- Async reset: `wb_rst_i` pulse between clock edges during RUN → all outputs 0 before the next edge, state IDLE.
- Saturation: `CNT_W`=4, `win_len`=15, `high_buf`=1 for all 16 samples → `out_data`=15.
